// File: rtl/streaming_fifo_param.sv
// streaming_fifo_param
//   Parametrised AXI-Stream FIFO placed on dataflow-partition boundaries.
//   Circular buffer with a registered input ready, an occupancy count,
//   programmable almost-full / almost-empty flags and a peak-occupancy
//   watermark used when sizing FIFOs.
//
//   Optional feature macro: STREAMING_FIFO_OUTREG_EN
//     defined   : output register stage after the memory; TDATA/TVALID come
//                 from flops, write-to-output latency is 2 cycles on an empty
//                 FIFO, the register entry is included in count.
//     undefined : asynchronous memory read, write-to-output latency 1 cycle.
//
// Ports
//   ap_clk          in   1      clock, rising edge
//   ap_rst          in   1      asynchronous active-high reset
//   in0_V_V_TDATA   in   WIDTH  input data
//   in0_V_V_TVALID  in   1      input valid
//   in0_V_V_TREADY  out  1      input ready (registered)
//   out_V_V_TDATA   out  WIDTH  output data (head entry)
//   out_V_V_TVALID  out  1      output valid
//   out_V_V_TREADY  in   1      output ready
//   count           out  CW     current occupancy, 0..DEPTH
//   almost_full     out  1      count >= AF_THRESH (registered)
//   almost_empty    out  1      count <= AE_THRESH (registered)
//   count_max       out  CW     peak count since reset / last clear
//   count_max_clr   in   1      synchronous clear of count_max
module streaming_fifo_param #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [WIDTH-1:0] in0_V_V_TDATA,
  input  logic             in0_V_V_TVALID,
  output logic             in0_V_V_TREADY,
  output logic [WIDTH-1:0] out_V_V_TDATA,
  output logic             out_V_V_TVALID,
  input  logic             out_V_V_TREADY,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count_max,
  input  logic             count_max_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    count_max_q;
  logic             in_ready_q;
  logic             af_q;
  logic             ae_q;
  logic             out_valid;
  logic             push;
  logic             pop;

  assign push       = in0_V_V_TVALID && in_ready_q;
  assign pop        = out_valid && out_V_V_TREADY;
  assign count_next = count_q + CW'(push) - CW'(pop);

  // Storage array; no reset so it can map onto RAM. Pointers wrap
  // naturally because DEPTH is a power of two.
  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem[wr_ptr] <= in0_V_V_TDATA;
    end
  end

  // Occupancy, write pointer and all status flags. Everything is computed
  // from count_next so the flags line up with count in the same cycle.
  // Ready only reopens after a pop has actually lowered the count, which
  // costs a one-cycle bubble when full but keeps the ready path registered.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      count_max_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      count_q    <= count_next;
      in_ready_q <= (count_next < DEPTH_C);
      af_q       <= (count_next >= AF_C);
      ae_q       <= (count_next <= AE_C);
      if (count_max_clr) begin
        count_max_q <= count_next;
      end else if (count_next > count_max_q) begin
        count_max_q <= count_next;
      end
    end
  end

`ifdef STREAMING_FIFO_OUTREG_EN
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [CW-1:0]    mem_count;
  logic             load;

  // Entries still in the array exclude the one parked in the output stage.
  // The stage reloads whenever it is empty or being popped, so a pop and a
  // refill happen in the same cycle and throughput is unaffected.
  assign mem_count = count_q - CW'(out_valid_q);
  assign load      = (mem_count != '0) && (!out_valid_q || out_V_V_TREADY);

  // Output register stage; the read pointer advances when an entry moves
  // from the array into the stage rather than on the downstream pop.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rd_ptr      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (load) begin
      out_data_q  <= mem[rd_ptr];
      rd_ptr      <= rd_ptr + 1'b1;
      out_valid_q <= 1'b1;
    end else if (pop) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_V_V_TDATA = out_data_q;
`else
  // Head entry read straight from the array; data stays put while the
  // consumer stalls because rd_ptr only moves on a pop.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign out_valid     = (count_q != '0);
  assign out_V_V_TDATA = mem[rd_ptr];
`endif

  assign in0_V_V_TREADY = in_ready_q;
  assign out_V_V_TVALID = out_valid;
  assign count          = count_q;
  assign almost_full    = af_q;
  assign almost_empty   = ae_q;
  assign count_max      = count_max_q;

endmodule
